// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master slice.
package apb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef logic [1:0] slave_id_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

endpackage

// File: rtl/apb_sel_decode.sv
// Slave id to one-hot select, with out-of-range flag.
module apb_sel_decode
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 4
) (
   input  slave_id_t             id,
   output logic [NUM_SLAVES-1:0] onehot,
   output logic                  oor
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         onehot[i] = (int'(id) == i);
      end
      oor = (int'(id) >= NUM_SLAVES);
   end

endmodule

// File: rtl/apb_master.sv
// APB master: IDLE/SETUP/ACCESS sequencer with command/response handshake.
// Optional ACCESS timeout under APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int NUM_SLAVES     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [1:0]            cmd_id,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  enable,
   output logic                  write,
   output logic [ADDR_W-1:0]     addr,
   output logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W-1:0]     rdata,
   input  logic                  ready
);

   state_t                  state;
   state_t                  state_n;
   slave_id_t               id_q;
   logic [NUM_SLAVES-1:0]   onehot;
   logic                    oor;
   logic                    accept;
   logic                    done;
   logic                    tmo;

   apb_sel_decode #(
      .NUM_SLAVES(NUM_SLAVES)
   ) u_dec (
      .id    (id_q),
      .onehot(onehot),
      .oor   (oor)
   );

   assign cmd_ready = !reset &&
                      ((state == IDLE) || (state == ACCESS && ready));
   assign accept    = cmd_valid && cmd_ready;
   assign sel       = (state == IDLE) ? '0 : onehot;
   assign enable    = (state == ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
      end else if (state_n == SETUP) begin
         tcnt <= '0;
      end else if (state == ACCESS && !ready) begin
         tcnt <= tcnt + CNT_W'(1);
      end
   end

   assign tmo = (state == ACCESS) && !ready &&
                (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_n = SETUP;
         end
         SETUP: begin
            state_n = ACCESS;
         end
         ACCESS: begin
            // out-of-range ids never reach a slave, so never wait on ready
            done = ready || oor || tmo;
            if (done) state_n = accept ? SETUP : IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_q      <= '0;
         write     <= 1'b0;
         addr      <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= done;
         if (done) begin
            rsp_err   <= oor || tmo;
            rsp_rdata <= (!write && !oor && ready) ? rdata : '0;
         end
         if (accept) begin
            id_q  <= cmd_id;
            write <= cmd_write;
            addr  <= cmd_addr;
            wdata <= cmd_wdata;
         end
      end
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width (one I2C byte).
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of one-hot select lines; slave id is 2 bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles with ready low (used only under APB_MASTER_TIMEOUT_EN).
REQ-005 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock for all logic; reset  in  1  synchronous, active-high.
REQ-006 SHALL have command ports: cmd_valid in 1 request present; cmd_ready out 1 request accepted; cmd_write in 1 1=write 0=read; cmd_id in 2 target slave; cmd_addr in ADDR_W; cmd_wdata in DATA_W.
REQ-007 SHALL have response ports: rsp_valid out 1 one-cycle completion pulse; rsp_rdata out DATA_W read data (0 for writes); rsp_err out 1 transfer aborted.
REQ-008 SHALL have APB ports: sel out NUM_SLAVES one-hot; enable out 1; write out 1; addr out ADDR_W; wdata out DATA_W; rdata in DATA_W; ready in 1.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, SETUP, ACCESS.
REQ-010 SHALL accept a command when cmd_valid && cmd_ready at a rising edge; cmd_ready = (state==IDLE) || (state==ACCESS && ready).
REQ-011 SHALL register write/id/addr/wdata on acceptance; APB outputs hold stable through SETUP and ACCESS.
REQ-012 IDLE: sel=0, enable=0; on acceptance go to SETUP.
REQ-013 SETUP: sel[cmd_id]=1, enable=0; lasts exactly one cycle, then ACCESS.
REQ-014 ACCESS: sel held, enable=1; stay while ready=0; on ready=1 transfer completes at that edge.
REQ-015 On completion with new command accepted same edge: go directly to SETUP (back-to-back, enable drops for one cycle, sel retargets); else go to IDLE with sel=0.
REQ-016 SHALL capture rdata at the completion edge for reads; rsp_valid=1 for exactly the following cycle with rsp_err=0.
REQ-017 Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS cycle N+2 -> with k wait cycles, rsp_valid in cycle N+3+k.
REQ-018 cmd_id beyond NUM_SLAVES-1 SHALL complete in one IDLE->SETUP->ACCESS pass without waiting on ready, rsp_err=1, no sel asserted.
REQ-019 write, addr, wdata SHALL retain last values in IDLE (no toggling).

Reset
REQ-020 On reset=1 at an edge: state=IDLE, sel=0, enable=0, write=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0.
REQ-021 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; sel/enable low from the next cycle.
REQ-022 cmd_ready SHALL be 0 while reset=1.

Configuration
REQ-023 Macro APB_MASTER_TIMEOUT_EN: when defined, a counter increments each ACCESS cycle with ready=0; on reaching TIMEOUT_CYCLES the transfer ends, state->IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-024 Without APB_MASTER_TIMEOUT_EN: ACCESS waits indefinitely; rsp_err asserts only per REQ-018; no counter logic.
REQ-025 Counter SHALL clear on entering SETUP; ready=1 on the timeout cycle SHALL count as normal completion.

Structure
REQ-026 Shared package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS), ADDR_W/DATA_W defaults, and slave id type.
REQ-027 Sub-module apb_sel_decode (2-bit id -> one-hot sel, out-of-range flag) is natural; FSM stays in apb_master.

Verification
REQ-028 Write id=1 addr=0x10 wdata=0xA5, 0 waits -> sel=4'b0010 SETUP then ACCESS, rsp_valid in cycle N+3, rsp_err=0.
REQ-029 Read id=2 addr=0x20, 5 wait cycles, rdata=0x3C on ready -> enable high 6 cycles, rsp_rdata=0x3C in cycle N+8.
REQ-030 Back-to-back write id=0 then read id=3, cmd_valid held -> enable drops one cycle, sel moves 0001->1000 without an IDLE cycle.
REQ-031 Reset asserted during ACCESS of a 3-wait write -> sel=0, enable=0 next cycle, no rsp_valid.
REQ-032 With APB_MASTER_TIMEOUT_EN, ready stuck 0 -> exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-033 NUM_SLAVES=3, cmd_id=3 -> sel stays 0, rsp_err=1 in cycle N+3.
